pipe_lsu: RTL and testbench
===========================

Name: pipe_lsu

Overview:
- Load/store stage between pipe_exu and pipe_wb.
- Accepts one executed uop per handshake from EX and issues a data-memory request for loads and stores over a valid/ready request channel with a response channel.
- Aligns and sign- or zero-extends load data, and presents a single registered writeback entry to WB.
- Non-memory uops pass through with one cycle of latency.

Parameters:
- XLEN, 32, data and address width.
- RST_PC, 32'h8000_0000, reset value of the pc_o register.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-low.
- ex_valid_i  in  1  EX has a valid uop.
- lsu_ready_o  out  1  LSU accepts the uop this cycle.
- ex_pc_i  in  XLEN  uop pc.
- ex_rd_i  in  5  destination register.
- ex_rd_wen_i  in  1  uop writes rd.
- ex_result_i  in  XLEN  ALU result; this is the effective address for memory uops.
- ex_is_load_i  in  1  load uop.
- ex_is_store_i  in  1  store uop.
- ex_size_i  in  2  access size: 0 byte, 1 half, 2 word.
- ex_unsigned_i  in  1  zero-extend load data.
- ex_store_data_i  in  XLEN  rs2 value for stores.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory accepts request.
- mem_req_addr_o  out  XLEN  word-aligned address.
- mem_req_wen_o  out  1  1 for store.
- mem_req_wdata_o  out  XLEN  lane-replicated store data.
- mem_req_wstrb_o  out  4  byte strobes.
- mem_rsp_valid_i  in  1  response (load data or store ack).
- mem_rsp_rdata_i  in  XLEN  word read data.
- lsu_valid_o  out  1  writeback entry valid.
- wb_ready_i  in  1  WB consumes entry.
- pc_o  out  XLEN  pc of entry.
- rd_o  out  5  destination.
- rd_wen_o  out  1  write enable.
- rd_wdata_o  out  XLEN  writeback data.
- misalign_o  out  1  one-cycle pulse when an access is suppressed as misaligned.

Behaviour:
- Reset (rst_i==0 at a clk_i edge):
  - state=IDLE, lsu_valid_o=0, mem_req_valid_o=0, misalign_o=0.
  - rd_o=0, rd_wen_o=0, rd_wdata_o=0, pc_o=RST_PC.
  - Reset mid-transaction drops the in-flight access; a mem_rsp_valid_i arriving while IDLE is ignored.
- Output register: one entry, drained when lsu_valid_o&&wb_ready_i.
- lsu_ready_o = (state==IDLE) && (!lsu_valid_o || wb_ready_i). This is combinational and does not depend on ex_valid_i.
- Accept occurs when ex_valid_i&&lsu_ready_o. The uop fields are latched into an internal holding register.
- Non-memory uop: the output register is loaded next cycle with rd_wdata=ex_result_i and rd_wen=ex_rd_wen_i. State stays IDLE, so back-to-back throughput is 1/cycle.
- Memory uop:
  - off = addr[1:0].
  - Misaligned when size==1 with off[0]==1, when size==2 with off!=0, or when size==3.
  - Misaligned access: no memory request is issued. misalign_o pulses for 1 cycle, and the output entry is loaded with rd_wen=0 and rd_wdata=0.
- State machine:
  - IDLE to REQ on accepting an aligned memory uop.
  - REQ: mem_req_valid_o=1 held, with stable addr/wen/wdata/wstrb, until mem_req_ready_i. Then go to RSP.
  - RSP: wait for mem_rsp_valid_i. On response, load the output entry and go to IDLE. The output register is always free at this point because it was empty or drained at accept.
  - Requests and responses are strictly one outstanding; an accept in the same cycle as a response is impossible because lsu_ready_o is 0 outside IDLE.
- Request encoding:
  - addr = {addr[XLEN-1:2],2'b00}.
  - wstrb: byte 4'b0001<<off, half 4'b0011<<off, word 4'b1111. Loads drive wstrb=0.
  - wdata: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- Load data:
  - sh = rdata >> (8*off).
  - Byte: sign-extend sh[7], or zero-extend when ex_unsigned_i.
  - Half: sign-extend sh[15], or zero-extend when ex_unsigned_i.
  - Word: sh.
  - rd_wen = latched ex_rd_wen_i.
- Store: on ack, the entry is written with rd_wen=0 and rd_wdata=0.
- Backpressure: while lsu_valid_o&&!wb_ready_i, all output fields hold stable.

Test Plan:
- Non-memory uops back-to-back: result 0x11 then 0x22, wb_ready_i=1 -> lsu_valid_o on consecutive cycles with rd_wdata 0x11 then 0x22, and lsu_ready_o stays 1.
- lb, addr 0x8000_0003, rdata 0x80FF_FF7F -> req addr 0x8000_0000, wstrb 0; rd_wdata 0xFFFF_FF80. With lbu the same access gives 0x0000_0080.
- sh, addr 0x1002, data 0x1234_ABCD -> wstrb 4'b1100, wdata 0xABCD_ABCD, wen=1; entry rd_wen=0 after ack.
- mem_req_ready_i low for 3 cycles and response 2 cycles later -> mem_req_valid_o held with stable fields for 4 cycles, lsu_ready_o=0 throughout, and exactly one entry is produced.
- lw at 0x1002 -> no mem_req_valid_o, misalign_o pulse, entry with rd_wen=0.
- wb_ready_i=0 with an entry pending -> lsu_ready_o=0 and outputs stable. Pulsing rst_i low during RSP -> IDLE, lsu_valid_o=0, and a later stray mem_rsp_valid_i produces no entry.

Source files
------------

// File: rtl/pipe_lsu.sv
// Load/store stage between EX and WB: at most one outstanding data-memory access and a
// single registered writeback entry. Non-memory uops pass through with one cycle of latency.
module pipe_lsu #(
  parameter int unsigned     XLEN   = 32,
  parameter logic [XLEN-1:0] RST_PC = 32'h8000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ex_valid_i,
  output logic            lsu_ready_o,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [4:0]      ex_rd_i,
  input  logic            ex_rd_wen_i,
  input  logic [XLEN-1:0] ex_result_i,
  input  logic            ex_is_load_i,
  input  logic            ex_is_store_i,
  input  logic [1:0]      ex_size_i,
  input  logic            ex_unsigned_i,
  input  logic [XLEN-1:0] ex_store_data_i,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [XLEN-1:0] mem_req_addr_o,
  output logic            mem_req_wen_o,
  output logic [XLEN-1:0] mem_req_wdata_o,
  output logic [3:0]      mem_req_wstrb_o,
  input  logic            mem_rsp_valid_i,
  input  logic [XLEN-1:0] mem_rsp_rdata_i,
  output logic            lsu_valid_o,
  input  logic            wb_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rd_o,
  output logic            rd_wen_o,
  output logic [XLEN-1:0] rd_wdata_o,
  output logic            misalign_o
);

  typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;
  state_e state_q, state_d;

  logic [XLEN-1:0] hold_pc_q;
  logic [4:0]      hold_rd_q;
  logic            hold_wen_q;
  logic [1:0]      hold_off_q;
  logic [1:0]      hold_size_q;
  logic            hold_uns_q;
  logic [XLEN-1:0] req_addr_q;
  logic [XLEN-1:0] req_wdata_q;
  logic            req_wen_q;
  logic [3:0]      req_wstrb_q;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [4:0]      rd_q, rd_d;
  logic            rd_wen_q, rd_wen_d;
  logic [XLEN-1:0] rd_wdata_q, rd_wdata_d;
  logic            misalign_q, misalign_d;

  logic            accept;
  logic            is_mem;
  logic            misaligned;
  logic [1:0]      off;
  logic [3:0]      wstrb_d;
  logic [XLEN-1:0] wdata_d;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_data;

  assign lsu_ready_o = (state_q == StIdle) && (!valid_q || wb_ready_i);
  assign accept      = ex_valid_i && lsu_ready_o;
  assign is_mem      = ex_is_load_i || ex_is_store_i;
  assign off         = ex_result_i[1:0];

  always_comb begin
    misaligned = 1'b0;
    case (ex_size_i)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = (off != 2'd0);
      default: misaligned = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so memory only needs the strobes.
  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = ex_store_data_i;
    case (ex_size_i)
      2'd0: begin
        wstrb_d = 4'b0001 << off;
        wdata_d = {4{ex_store_data_i[7:0]}};
      end
      2'd1: begin
        wstrb_d = 4'b0011 << off;
        wdata_d = {2{ex_store_data_i[15:0]}};
      end
      default: wstrb_d = 4'b1111;
    endcase
    if (!ex_is_store_i) wstrb_d = 4'b0000;
  end

  assign shifted = mem_rsp_rdata_i >> {hold_off_q, 3'b000};

  always_comb begin
    load_data = shifted;
    case (hold_size_q)
      2'd0:    load_data = {{(XLEN-8){!hold_uns_q && shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = {{(XLEN-16){!hold_uns_q && shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && is_mem && !misaligned) state_d = StReq;
      StReq:   if (mem_req_ready_i) state_d = StRsp;
      StRsp:   if (mem_rsp_valid_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The output entry is always free when a response arrives: it was empty or drained at accept.
  always_comb begin
    valid_d    = valid_q && !wb_ready_i;
    pc_d       = pc_q;
    rd_d       = rd_q;
    rd_wen_d   = rd_wen_q;
    rd_wdata_d = rd_wdata_q;
    misalign_d = 1'b0;
    if (accept && (!is_mem || misaligned)) begin
      valid_d    = 1'b1;
      pc_d       = ex_pc_i;
      rd_d       = ex_rd_i;
      rd_wen_d   = is_mem ? 1'b0 : ex_rd_wen_i;
      rd_wdata_d = is_mem ? '0 : ex_result_i;
      misalign_d = is_mem;
    end else if ((state_q == StRsp) && mem_rsp_valid_i) begin
      valid_d    = 1'b1;
      pc_d       = hold_pc_q;
      rd_d       = hold_rd_q;
      rd_wen_d   = !req_wen_q && hold_wen_q;
      rd_wdata_d = req_wen_q ? '0 : load_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      valid_q    <= 1'b0;
      pc_q       <= RST_PC;
      rd_q       <= 5'd0;
      rd_wen_q   <= 1'b0;
      rd_wdata_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rd_q       <= rd_d;
      rd_wen_q   <= rd_wen_d;
      rd_wdata_q <= rd_wdata_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      hold_pc_q   <= ex_pc_i;
      hold_rd_q   <= ex_rd_i;
      hold_wen_q  <= ex_rd_wen_i;
      hold_off_q  <= off;
      hold_size_q <= ex_size_i;
      hold_uns_q  <= ex_unsigned_i;
      req_addr_q  <= {ex_result_i[XLEN-1:2], 2'b00};
      req_wdata_q <= wdata_d;
      req_wen_q   <= ex_is_store_i;
      req_wstrb_q <= wstrb_d;
    end
  end

  assign mem_req_valid_o = (state_q == StReq);
  assign mem_req_addr_o  = req_addr_q;
  assign mem_req_wen_o   = req_wen_q;
  assign mem_req_wdata_o = req_wdata_q;
  assign mem_req_wstrb_o = req_wstrb_q;

  assign lsu_valid_o = valid_q;
  assign pc_o        = pc_q;
  assign rd_o        = rd_q;
  assign rd_wen_o    = rd_wen_q;
  assign rd_wdata_o  = rd_wdata_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_pipe_lsu.sv
// Bench for pipe_lsu: a word-array memory model predicts every request and writeback entry;
// directed cases pin the model to hand-computed values, then randomized uops run against it.
module tb_pipe_lsu;
  localparam logic [31:0] RstPc = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic        lsu_ready_o;
  logic [31:0] ex_pc_i = '0;
  logic [4:0]  ex_rd_i = '0;
  logic        ex_rd_wen_i = 1'b0;
  logic [31:0] ex_result_i = '0;
  logic        ex_is_load_i = 1'b0;
  logic        ex_is_store_i = 1'b0;
  logic [1:0]  ex_size_i = '0;
  logic        ex_unsigned_i = 1'b0;
  logic [31:0] ex_store_data_i = '0;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b0;
  logic [31:0] mem_req_addr_o;
  logic        mem_req_wen_o;
  logic [31:0] mem_req_wdata_o;
  logic [3:0]  mem_req_wstrb_o;
  logic        mem_rsp_valid_i = 1'b0;
  logic [31:0] mem_rsp_rdata_i = '0;
  logic        lsu_valid_o;
  logic        wb_ready_i = 1'b0;
  logic [31:0] pc_o;
  logic [4:0]  rd_o;
  logic        rd_wen_o;
  logic [31:0] rd_wdata_o;
  logic        misalign_o;

  always #5 clk = ~clk;

  pipe_lsu #(.XLEN(32), .RST_PC(RstPc)) dut (
    .clk_i(clk), .rst_i(rst_i), .ex_valid_i(ex_valid_i), .lsu_ready_o(lsu_ready_o),
    .ex_pc_i(ex_pc_i), .ex_rd_i(ex_rd_i), .ex_rd_wen_i(ex_rd_wen_i), .ex_result_i(ex_result_i),
    .ex_is_load_i(ex_is_load_i), .ex_is_store_i(ex_is_store_i), .ex_size_i(ex_size_i),
    .ex_unsigned_i(ex_unsigned_i), .ex_store_data_i(ex_store_data_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_wen_o(mem_req_wen_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_req_wstrb_o(mem_req_wstrb_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_rdata_i(mem_rsp_rdata_i),
    .lsu_valid_o(lsu_valid_o), .wb_ready_i(wb_ready_i), .pc_o(pc_o), .rd_o(rd_o),
    .rd_wen_o(rd_wen_o), .rd_wdata_o(rd_wdata_o), .misalign_o(misalign_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] wd;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] res;
    logic        ld;
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] sd;
    int          stall;
    int          dly;
  } uop_t;

  uop_t        q[$];
  logic [31:0] mem_m[16];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;

  // Model state: phase 0 idle, 1 request outstanding, 2 waiting for response.
  logic        valid_m = 1'b0;
  logic        mis_m = 1'b0;
  ent_t        cur;
  ent_t        pend;
  int          phase = 0;
  int          stall_cnt = 0;
  int          dly_cnt = 0;
  logic [3:0]  req_idx = '0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;
  logic        exp_wen = 1'b0;
  logic [3:0]  exp_wstrb = '0;

  int          wb_mode = 0;
  int          gap_en = 0;
  int          stray_en = 0;
  int          rst_req = 0;
  int          rst_chk = 0;
  int          req_cycles = 0;
  int          last_req_cycles = 0;
  int          mis_pulses = 0;
  int          any_req = 0;
  logic [31:0] last_addr = '0;
  logic [3:0]  last_wstrb = '0;
  logic [31:0] last_wdata = '0;
  logic        last_wen = 1'b0;
  int          cons_cyc[$];
  logic [31:0] cons_dut[$];
  logic [31:0] cons_m[$];
  logic        cons_wen_dut[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic uop_t mk(input int kind, input logic [31:0] res, input logic [1:0] size,
                              input logic uns, input logic [31:0] sd, input int stall,
                              input int dly);
    uop_t u;
    u.pc    = $urandom;
    u.rd    = 5'($urandom_range(1, 31));
    u.wen   = 1'b1;
    u.res   = res;
    u.ld    = (kind == 1);
    u.st    = (kind == 2);
    u.size  = size;
    u.uns   = uns;
    u.sd    = sd;
    u.stall = stall;
    u.dly   = dly;
    return u;
  endfunction

  task automatic clear_logs();
    cons_cyc.delete();
    cons_dut.delete();
    cons_m.delete();
    cons_wen_dut.delete();
  endtask

  task automatic step();
    logic wbr, do_rst, have, rdy_e, mis, rspv, n_valid, n_mis;
    uop_t u;
    ent_t n_cur;
    int n_phase, nb;
    logic [1:0] off;
    logic [31:0] w, v, m;
    @(negedge clk);
    cyc++;
    if (rst_chk != 0) begin
      chk("rst_pc", pc_o, RstPc);
      chk("rst_rd", 32'(rd_o), 32'd0);
      chk("rst_rd_wen", 32'(rd_wen_o), 32'd0);
      chk("rst_rd_wdata", rd_wdata_o, 32'd0);
      rst_chk = 0;
    end
    chk("lsu_valid", 32'(lsu_valid_o), 32'(valid_m));
    if (valid_m) begin
      chk("pc", pc_o, cur.pc);
      chk("rd", 32'(rd_o), 32'(cur.rd));
      chk("rd_wen", 32'(rd_wen_o), 32'(cur.wen));
      chk("rd_wdata", rd_wdata_o, cur.wd);
    end
    chk("misalign", 32'(misalign_o), 32'(mis_m));
    if (misalign_o) mis_pulses++;
    if (mem_req_valid_o) any_req++;
    chk("req_valid", 32'(mem_req_valid_o), 32'(phase == 1));
    if (phase == 1) begin
      chk("req_addr", mem_req_addr_o, exp_addr);
      chk("req_wen", 32'(mem_req_wen_o), 32'(exp_wen));
      chk("req_wstrb", 32'(mem_req_wstrb_o), 32'(exp_wstrb));
      if (exp_wen) chk("req_wdata", mem_req_wdata_o, exp_wdata);
      if (mem_req_valid_o) req_cycles++;
    end

    wbr = (wb_mode == 0) ? 1'b1 : (wb_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
    wb_ready_i = wbr;
    do_rst = (rst_req != 0) && (phase == 2);
    rst_i = !do_rst;
    mem_req_ready_i = (phase == 1) ? (stall_cnt == 0) : 1'($urandom_range(0, 1));
    if (phase == 2) rspv = (dly_cnt == 0) && !do_rst;
    else if (phase == 0 && stray_en == 2) rspv = 1'b1;
    else rspv = (phase == 0) && (stray_en == 1) && ($urandom_range(0, 3) == 0);
    mem_rsp_valid_i = rspv;
    mem_rsp_rdata_i = (phase == 2) ? mem_m[req_idx] : $urandom;
    have = (q.size() > 0) && !do_rst && ((gap_en == 0) || ($urandom_range(0, 3) != 0));
    if (have) begin
      u = q[0];
      ex_valid_i = 1'b1; ex_pc_i = u.pc; ex_rd_i = u.rd; ex_rd_wen_i = u.wen;
      ex_result_i = u.res; ex_is_load_i = u.ld; ex_is_store_i = u.st; ex_size_i = u.size;
      ex_unsigned_i = u.uns; ex_store_data_i = u.sd;
    end else begin
      ex_valid_i = 1'b0; ex_result_i = $urandom; ex_is_load_i = 1'($urandom_range(0, 1));
      ex_is_store_i = 1'b0; ex_size_i = 2'($urandom_range(0, 3)); ex_store_data_i = $urandom;
    end
    #1;
    rdy_e = (phase == 0) && (!valid_m || wbr);
    chk("lsu_ready", 32'(lsu_ready_o), 32'(rdy_e));

    if (do_rst) begin
      valid_m = 1'b0; mis_m = 1'b0; phase = 0;
      cur = '{RstPc, 5'd0, 1'b0, 32'd0};
      rst_req = 0; rst_chk = 1;
    end else begin
      n_valid = valid_m && !wbr; n_cur = cur; n_mis = 1'b0; n_phase = phase;
      if (valid_m && wbr) begin
        cons_cyc.push_back(cyc); cons_dut.push_back(rd_wdata_o);
        cons_m.push_back(cur.wd); cons_wen_dut.push_back(rd_wen_o);
      end
      if (phase == 1) begin
        if (stall_cnt == 0) begin
          n_phase = 2; last_req_cycles = req_cycles; req_cycles = 0;
          last_addr = mem_req_addr_o; last_wstrb = mem_req_wstrb_o;
          last_wdata = mem_req_wdata_o; last_wen = mem_req_wen_o;
        end else stall_cnt--;
      end else if (phase == 2) begin
        if (dly_cnt == 0) begin
          n_phase = 0; n_valid = 1'b1; n_cur = pend;
        end else dly_cnt--;
      end
      if (have && rdy_e) begin
        u = q.pop_front();
        if (!u.ld && !u.st) begin
          n_valid = 1'b1; n_cur = '{u.pc, u.rd, u.wen, u.res};
        end else begin
          off = u.res[1:0];
          nb = (u.size == 0) ? 1 : (u.size == 1) ? 2 : 4;
          mis = (u.size == 3) || ((int'(off) % nb) != 0);
          if (mis) begin
            n_valid = 1'b1; n_mis = 1'b1; n_cur = '{u.pc, u.rd, 1'b0, 32'd0};
          end else begin
            n_phase = 1; stall_cnt = u.stall; dly_cnt = u.dly; req_idx = u.res[5:2];
            exp_addr = u.res & 32'hFFFF_FFFC; exp_wen = u.st;
            m = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
            w = mem_m[req_idx];
            if (u.st) begin
              exp_wstrb = 4'(((1 << nb) - 1) << off);
              exp_wdata = (nb == 1) ? u.sd[7:0] * 32'h0101_0101 :
                          (nb == 2) ? u.sd[15:0] * 32'h0001_0001 : u.sd;
              for (int k = 0; k < nb; k++) w[8 * (int'(off) + k) +: 8] = u.sd[8 * k +: 8];
              mem_m[req_idx] = w;
              pend = '{u.pc, u.rd, 1'b0, 32'd0};
            end else begin
              exp_wstrb = 4'd0; exp_wdata = 32'd0;
              v = (w >> (8 * int'(off))) & m;
              if (!u.uns && nb < 4 && v[8 * nb - 1]) v = v | ~m;
              pend = '{u.pc, u.rd, u.wen, v};
            end
          end
        end
      end
      valid_m = n_valid; cur = n_cur; mis_m = n_mis; phase = n_phase;
    end
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((q.size() > 0 || phase != 0 || valid_m) && n < maxc) begin
      step();
      n++;
    end
    chk("drain_left", q.size() + phase + int'(valid_m), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    uop_t u;
    int kind, sz;
    logic [31:0] a;
    cur = '{RstPc, 5'd0, 1'b0, 32'd0};
    for (int i = 0; i < 16; i++) mem_m[i] = $urandom;
    repeat (3) @(negedge clk);
    chk("rst_lsu_valid", 32'(lsu_valid_o), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid_o), 32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    chk("rst_pc", pc_o, RstPc);
    chk("rst_rd", 32'(rd_o), 32'd0);
    chk("rst_rd_wen", 32'(rd_wen_o), 32'd0);
    chk("rst_rd_wdata", rd_wdata_o, 32'd0);
    rst_i = 1'b1;

    // Back-to-back non-memory uops.
    clear_logs();
    q.push_back(mk(0, 32'h11, 2'd0, 1'b0, 32'd0, 0, 0));
    q.push_back(mk(0, 32'h22, 2'd0, 1'b0, 32'd0, 0, 0));
    drain(50);
    chk("b2b_count", cons_cyc.size(), 2);
    if (cons_cyc.size() == 2) begin
      chk("b2b_first", cons_dut[0], 32'h11);
      chk("b2b_model_first", cons_m[0], 32'h11);
      chk("b2b_second", cons_dut[1], 32'h22);
      chk("b2b_gap", cons_cyc[1] - cons_cyc[0], 1);
    end

    // lb / lbu from the top byte.
    clear_logs();
    mem_m[0] = 32'h80FF_FF7F;
    q.push_back(mk(1, 32'h8000_0003, 2'd0, 1'b0, 32'd0, 0, 0));
    q.push_back(mk(1, 32'h8000_0003, 2'd0, 1'b1, 32'd0, 1, 1));
    drain(50);
    chk("lb_count", cons_cyc.size(), 2);
    if (cons_cyc.size() == 2) begin
      chk("lb_data", cons_dut[0], 32'hFFFF_FF80);
      chk("lb_model", cons_m[0], 32'hFFFF_FF80);
      chk("lbu_data", cons_dut[1], 32'h0000_0080);
      chk("lbu_model", cons_m[1], 32'h0000_0080);
    end
    chk("lb_req_addr", last_addr, 32'h8000_0000);
    chk("lb_req_wstrb", 32'(last_wstrb), 32'd0);

    // sh to the upper half.
    clear_logs();
    q.push_back(mk(2, 32'h0000_1002, 2'd1, 1'b0, 32'h1234_ABCD, 0, 0));
    drain(50);
    chk("sh_wstrb", 32'(last_wstrb), 32'hC);
    chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
    chk("sh_wen", 32'(last_wen), 32'd1);
    chk("sh_count", cons_cyc.size(), 1);
    if (cons_cyc.size() == 1) chk("sh_rd_wen", 32'(cons_wen_dut[0]), 32'd0);

    // Request stalled 3 cycles, response 2 cycles after acceptance.
    clear_logs();
    q.push_back(mk(1, 32'h0000_2000, 2'd2, 1'b0, 32'd0, 3, 2));
    drain(50);
    chk("stall_req_cycles", last_req_cycles, 4);
    chk("stall_count", cons_cyc.size(), 1);

    // Misaligned word load.
    clear_logs();
    mis_pulses = 0; any_req = 0;
    q.push_back(mk(1, 32'h0000_1002, 2'd2, 1'b0, 32'd0, 0, 0));
    drain(50);
    chk("mis_pulses", mis_pulses, 1);
    chk("mis_no_req", any_req, 0);
    chk("mis_count", cons_cyc.size(), 1);
    if (cons_cyc.size() == 1) chk("mis_rd_wen", 32'(cons_wen_dut[0]), 32'd0);

    // WB backpressure holds the entry and blocks EX.
    clear_logs();
    wb_mode = 2;
    q.push_back(mk(0, 32'h77, 2'd0, 1'b0, 32'd0, 0, 0));
    q.push_back(mk(0, 32'h88, 2'd0, 1'b0, 32'd0, 0, 0));
    repeat (6) step();
    chk("bp_ready", 32'(lsu_ready_o), 32'd0);
    chk("bp_wdata", rd_wdata_o, 32'h77);
    wb_mode = 0;
    drain(50);
    chk("bp_count", cons_cyc.size(), 2);
    if (cons_cyc.size() == 2) chk("bp_second", cons_dut[1], 32'h88);

    // Reset while waiting for a response, then stray responses while idle.
    clear_logs();
    rst_req = 1;
    q.push_back(mk(1, 32'h0000_3000, 2'd2, 1'b0, 32'd0, 0, 3));
    drain(50);
    stray_en = 2;
    repeat (5) step();
    stray_en = 0;
    chk("rst_drop_count", cons_cyc.size(), 0);
    chk("stray_valid", 32'(lsu_valid_o), 32'd0);

    // Randomized traffic.
    clear_logs();
    wb_mode = 1; gap_en = 1; stray_en = 1;
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 2);
      sz = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 1) a[0] = 1'b0;
        if (sz == 2) a[1:0] = 2'b00;
      end
      u = mk(kind, a, 2'(sz), 1'($urandom_range(0, 1)), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
      u.wen = 1'($urandom_range(0, 1));
      q.push_back(u);
    end
    drain(20000);
    chk("rand_entries", cons_cyc.size(), 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
